// File: rtl/rom_arbiter_pkg.sv
// Shared types and default widths for the two-requester ImgROM burst arbiter.
package rom_arbiter_pkg;

  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 8;
  localparam int LEN_W      = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/rom_arbiter_if.sv
// Bundle of requester, ROM and read-return signals around the ROM arbiter.
// The slave side is the arbiter; the master side is the requesters plus ROM.
interface rom_arbiter_if
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [LEN_W-1:0]  len0;
  logic [LEN_W-1:0]  len1;
  logic              gnt0;
  logic              gnt1;
  logic              rom_cen;
  logic [ADDR_W-1:0] rom_a;
  logic [DATA_W-1:0] rom_q;
  logic              rd_valid;
  logic              rd_id;
  logic              rd_last;
  logic [DATA_W-1:0] rd_data;
  logic              busy;

  modport slave (
    input  req0, req1, addr0, addr1, len0, len1, rom_q,
    output gnt0, gnt1, rom_cen, rom_a, rd_valid, rd_id, rd_last, rd_data, busy
  );

  modport master (
    output req0, req1, addr0, addr1, len0, len1, rom_q,
    input  gnt0, gnt1, rom_cen, rom_a, rd_valid, rd_id, rd_last, rd_data, busy
  );

endinterface

// File: rtl/rom_arbiter_rr_arb2.sv
// Two-way round-robin picker: one-hot grant from two requests, with a
// preference pointer that moves to the losing side after each grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;

  // Pick the preferred requester on a tie, otherwise whoever is asking.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

  // After a grant, prefer the requester that did not just win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// ImgROM burst arbiter: grants one of two requesters, issues LEN+1
// consecutive ROM reads with a wrapping address, and tags the returned words.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  rom_arbiter_if.slave  bus
);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              owner_q;
  logic              gnt0_q;
  logic              gnt1_q;
  logic              rd_valid_q;
  logic              rd_id_q;
  logic              rd_last_q;
  logic [DATA_W-1:0] rd_word;
  logic [1:0]        pick;
  logic              grant_now;
  logic              last_issue;

  // A grant is only taken from IDLE, so a request still high on the edge
  // that ends the grant cycle is never mistaken for a new one.
  assign grant_now  = (state == IDLE) && (bus.req0 || bus.req1);
  assign last_issue = (state == ISSUE) && (cnt_q == '0);

  rr_arb2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({bus.req1, bus.req0}),
    .advance (grant_now),
    .gnt     (pick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: enter ISSUE on a grant, leave after the final word is issued.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_now)  state_next = ISSUE;
      ISSUE:   if (last_issue) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Burst datapath: latch the winner's address/length, then walk the address
  // while counting down; the address register holds its last value in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      cnt_q      <= '0;
      owner_q    <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_id_q    <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      gnt0_q     <= grant_now && pick[0];
      gnt1_q     <= grant_now && pick[1];
      rd_valid_q <= (state == ISSUE);
      rd_id_q    <= owner_q;
      rd_last_q  <= last_issue;
      if (grant_now) begin
        addr_q  <= pick[1] ? bus.addr1 : bus.addr0;
        cnt_q   <= pick[1] ? bus.len1 : bus.len0;
        owner_q <= pick[1];
      end else if ((state == ISSUE) && (cnt_q != '0)) begin
        addr_q <= addr_q + ADDR_W'(1);
        cnt_q  <= cnt_q - LEN_W'(1);
      end
    end
  end

  assign rd_word      = bus.rom_q;
  assign bus.rd_data  = rd_word;
  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.rom_cen  = (state != ISSUE);
  assign bus.rom_a    = addr_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_id    = rd_id_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.busy     = (state == ISSUE);

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: expected grants, ROM issues and returned
// words are queued as stimulus is applied and compared as the DUT produces them.
module tb_rom_arbiter;
  import rom_arbiter_pkg::*;

  localparam int AW = 14;
  localparam int DW = 8;

  typedef struct {
    logic [AW-1:0] addr;
    int            gap;
  } issue_t;

  typedef struct {
    int            id;
    int            last;
    logic [DW-1:0] data;
  } read_t;

  logic clk;
  logic rst_n;

  rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  rom_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int            gntQ[$];
  issue_t        issueQ[$];
  read_t         readQ[$];
  int            checks;
  int            passes;
  int            cycle;
  int            lastIssueCycle;
  bit            monitorOn;
  int            left0;
  int            left1;
  logic [AW-1:0] lastPushedAddr;
  int            expGnt;
  issue_t        expIssue;
  read_t         expRead;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM contents as a fixed function of the address.
  function automatic logic [DW-1:0] romFn(input logic [AW-1:0] a);
    return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h5A;
  endfunction

  // Synchronous ROM model: data appears the cycle after an enabled read.
  always @(posedge clk) begin
    if (bus.rom_cen === 1'b0) bus.rom_q <= romFn(bus.rom_a);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
  endtask

  // Queue the grant, every issued address and every returned word of a burst.
  task automatic pushBurst(input int id, input logic [AW-1:0] addr, input int len,
                           input int gap);
    issue_t ie;
    read_t  re;
    logic [AW-1:0] a;
    gntQ.push_back(id);
    for (int i = 0; i <= len; i++) begin
      a = addr + AW'(i);
      ie.addr = a;
      ie.gap  = (i == 0) ? gap : 0;
      issueQ.push_back(ie);
      re.id   = id;
      re.last = (i == len) ? 1 : 0;
      re.data = romFn(a);
      readQ.push_back(re);
      lastPushedAddr = a;
    end
  endtask

  task automatic applyStimulus(input int id, input logic [AW-1:0] addr,
                               input logic [LEN_W-1:0] len, input int bursts);
    if (id == 0) begin
      bus.req0 = 1'b1; bus.addr0 = addr; bus.len0 = len; left0 = bursts;
    end else begin
      bus.req1 = 1'b1; bus.addr1 = addr; bus.len1 = len; left1 = bursts;
    end
  endtask

  // One clock: sample grants mid-cycle, then after the edge that saw them
  // release a requester whose burst count is used up.
  task automatic stepCycle();
    bit g0, g1;
    @(negedge clk);
    g0 = (bus.gnt0 === 1'b1);
    g1 = (bus.gnt1 === 1'b1);
    @(posedge clk);
    #1;
    if (g0) begin
      if (left0 > 0) left0--;
      if (left0 == 0) bus.req0 = 1'b0;
    end
    if (g1) begin
      if (left1 > 0) left1--;
      if (left1 == 0) bus.req1 = 1'b0;
    end
  endtask

  task automatic runUntilDrained(input string tag, input int budget);
    int n;
    n = 0;
    while (((gntQ.size() + issueQ.size() + readQ.size()) != 0 || left0 != 0 || left1 != 0)
           && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput({tag, "_pending"}, gntQ.size() + issueQ.size() + readQ.size(), 0);
    repeat (2) stepCycle();
    checkOutput({tag, "_rom_a_hold"}, bus.rom_a, lastPushedAddr);
    checkOutput({tag, "_cen_idle"}, bus.rom_cen, 1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rom_cen"}, bus.rom_cen, 1);
    checkOutput({tag, "_rom_a"}, bus.rom_a, 0);
    checkOutput({tag, "_gnt0"}, bus.gnt0, 0);
    checkOutput({tag, "_gnt1"}, bus.gnt1, 0);
    checkOutput({tag, "_rd_valid"}, bus.rd_valid, 0);
    checkOutput({tag, "_rd_last"}, bus.rd_last, 0);
    checkOutput({tag, "_rd_id"}, bus.rd_id, 0);
    checkOutput({tag, "_busy"}, bus.busy, 0);
  endtask

  // Monitor: compare grants, ROM issue cycles and returned words to the queues.
  always @(negedge clk) begin
    cycle++;
    if (monitorOn && rst_n === 1'b1) begin
      if (bus.gnt0 === 1'b1 || bus.gnt1 === 1'b1) begin
        checkOutput("gnt_expected", gntQ.size() > 0, 1);
        checkOutput("gnt_onehot", bus.gnt0 & bus.gnt1, 0);
        checkOutput("gnt_with_issue", bus.rom_cen, 0);
        if (gntQ.size() > 0) begin
          expGnt = gntQ.pop_front();
          checkOutput("gnt_id", bus.gnt1, expGnt);
        end
      end
      if (bus.rom_cen !== 1'b1) begin
        checkOutput("issue_expected", issueQ.size() > 0, 1);
        checkOutput("busy_issue", bus.busy, 1);
        if (issueQ.size() > 0) begin
          expIssue = issueQ.pop_front();
          checkOutput("issue_addr", bus.rom_a, expIssue.addr);
          if (expIssue.gap != 0)
            checkOutput("issue_gap", cycle - lastIssueCycle, expIssue.gap);
        end
        lastIssueCycle = cycle;
      end
      if (bus.rd_valid !== 1'b0) begin
        checkOutput("read_expected", readQ.size() > 0, 1);
        if (readQ.size() > 0) begin
          expRead = readQ.pop_front();
          checkOutput("rd_id", bus.rd_id, expRead.id);
          checkOutput("rd_last", bus.rd_last, expRead.last);
          checkOutput("rd_data", bus.rd_data, expRead.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0; passes = 0; cycle = 0; lastIssueCycle = 0;
    monitorOn = 1'b0; left0 = 0; left1 = 0; lastPushedAddr = '0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.len0 = '0; bus.len1 = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("por");
    rst_n = 1'b1;
    monitorOn = 1'b1;
    @(posedge clk);
    #1;

    // Single burst from requester 0.
    pushBurst(0, 14'h0010, 3, 0);
    applyStimulus(0, 14'h0010, 4'd3, 1);
    runUntilDrained("single", 50);

    // Address wrap on requester 1.
    pushBurst(1, 14'h3FFE, 2, 0);
    applyStimulus(1, 14'h3FFE, 4'd2, 1);
    runUntilDrained("wrap", 50);

    // Reset in the middle of a burst; the pointer now prefers requester 1.
    pushBurst(0, 14'h0100, 7, 0);
    applyStimulus(0, 14'h0100, 4'd7, 1);
    repeat (4) stepCycle();
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("mid_burst");
    gntQ.delete(); issueQ.delete(); readQ.delete();
    left0 = 0; left1 = 0; bus.req0 = 1'b0; bus.req1 = 1'b0;
    lastPushedAddr = '0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_rd_valid", bus.rd_valid, 0);
      checkOutput("rst_rom_cen", bus.rom_cen, 1);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contention straight after reset: requester 0 first, then one bubble.
    pushBurst(0, 14'h0020, 2, 0);
    pushBurst(1, 14'h0040, 1, 2);
    applyStimulus(0, 14'h0020, 4'd2, 1);
    applyStimulus(1, 14'h0040, 4'd1, 1);
    runUntilDrained("contention", 50);

    // Fairness: both keep requesting single-word bursts.
    for (int k = 0; k < 3; k++) begin
      pushBurst(0, 14'h0050, 0, (k == 0) ? 0 : 2);
      pushBurst(1, 14'h0060, 0, 2);
    end
    applyStimulus(0, 14'h0050, 4'd0, 3);
    applyStimulus(1, 14'h0060, 4'd0, 3);
    runUntilDrained("fairness", 60);

    // Maximum length burst with requester 1 arriving mid-burst.
    pushBurst(0, 14'h0200, 15, 0);
    applyStimulus(0, 14'h0200, 4'd15, 1);
    repeat (6) stepCycle();
    pushBurst(1, 14'h0300, 0, 2);
    applyStimulus(1, 14'h0300, 4'd0, 1);
    runUntilDrained("maxlen", 80);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 14, meaning the ImgROM address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the ImgROM word width.
REQ-003 The block SHALL have port CLK, input, 1, single clock (all logic on rising edge).
REQ-004 The block SHALL have port RST_N, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have ports REQ0 and REQ1, input, 1 each, burst request from requester 0 or 1.
REQ-006 The block SHALL have ports ADDR0 and ADDR1, input, ADDR_W each, burst start address.
REQ-007 The block SHALL have ports LEN0 and LEN1, input, 4 each, burst length minus one (1..16 words).
REQ-008 The block SHALL have ports GNT0 and GNT1, output, 1 each, one-cycle grant pulse.
REQ-009 The block SHALL have ports ROM_CEN (output, 1, active-low ROM enable), ROM_A (output, ADDR_W, ROM address) and ROM_Q (input, DATA_W, ROM data).
REQ-010 The block SHALL have ports RD_VALID, RD_ID, RD_LAST, RD_DATA (outputs, 1/1/1/DATA_W): returned-word strobe, owning requester, last word of burst, data.
REQ-011 The block SHALL have port BUSY, output, 1, high while a burst is being issued.

Function
REQ-012 States SHALL be IDLE and ISSUE; the reset state SHALL be IDLE.
REQ-013 Handshake: requester holds REQx high, with ADDRx/LENx stable, until it samples GNTx high; REQx sampled on the same edge as GNTx is not a new request.
REQ-014 In IDLE with any REQ high, on the next edge: GNTx=1 for one cycle, ADDRx/LENx latched, state goes to ISSUE.
REQ-015 Arbitration SHALL be round-robin: a 1-bit pointer selects the preferred requester on simultaneous requests, and toggles to the other requester after every grant.
REQ-016 A lone request SHALL be granted regardless of the pointer.
REQ-017 In ISSUE, ROM_CEN=0 and ROM_A=current address every cycle, for exactly LEN+1 consecutive cycles.
REQ-018 The address SHALL increment by 1 each cycle, wrapping from 2^ADDR_W-1 to 0.
REQ-019 After the last issue cycle the state SHALL return to IDLE.
REQ-020 ROM_CEN SHALL be 1 whenever not in ISSUE; ROM_A SHALL hold its last value in IDLE.
REQ-021 Read latency: RD_VALID SHALL be a register set one cycle after each ROM_CEN=0 cycle; RD_DATA SHALL equal ROM_Q combinationally.
REQ-022 RD_ID SHALL be registered alongside RD_VALID; RD_LAST=1 with the final word of a burst.
REQ-023 A new grant MAY occur in the IDLE cycle in which the previous burst's last word is returned, giving exactly one ROM_CEN=1 bubble between back-to-back bursts.
REQ-024 BUSY SHALL equal (state==ISSUE).
REQ-025 REQx changes during ISSUE SHALL not affect the current burst.

Reset
REQ-026 On RST_N low, asynchronously: state=IDLE, ROM_CEN=1, ROM_A=0, GNT0/1=0, RD_VALID=0, RD_LAST=0, RD_ID=0, BUSY=0, pointer=0 (requester 0 preferred).
REQ-027 Reset asserted mid-burst SHALL abort the burst: no further RD_VALID, and no grant until RST_N has been high for one edge.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, ISSUE), LEN width (4) and default ADDR_W/DATA_W.
REQ-029 The round-robin pick and pointer SHALL be a sub-module rr_arb2 (2 requests in, one-hot grant out, advance input).

Verification
REQ-030 Reset: assert RST_N=0 mid-burst -> ROM_CEN=1, RD_VALID=0 immediately, with all outputs at their REQ-026 values.
REQ-031 Single burst: REQ0=1, ADDR0=0x0010, LEN0=3 -> GNT0 pulse, then ROM_A=0x10..0x13 on 4 cycles with ROM_CEN=0, then 4 RD_VALID, RD_ID=0, RD_LAST on the 4th word, data matching ROM contents.
REQ-032 Contention: REQ0 and REQ1 high together from reset -> GNT0 first, GNT1 after burst 0, one bubble cycle between the bursts.
REQ-033 Fairness: both requesters continuously requesting LEN=0 -> grants alternate 0,1,0,1; ROM_CEN=0 on every second cycle.
REQ-034 Wrap: ADDR1=0x3FFE, LEN1=2 -> ROM_A sequence 0x3FFE, 0x3FFF, 0x0000.
REQ-035 Max length: LEN0=15 -> exactly 16 ROM_CEN=0 cycles and 16 RD_VALID; REQ1 raised mid-burst is granted only after the burst ends.
